// File: rtl/minicar_pkg.sv
// Shared miniCar constants: system clock, clock-divider ratios and the
// frequency-meter state encoding / default gate length.
package minicar_pkg;

  // System clock and the divider ratios derived from it.
  localparam int unsigned SYS_CLK_HZ    = 100_000_000;
  localparam int unsigned CLKDIV_1MHZ   = SYS_CLK_HZ / 1_000_000;
  localparam int unsigned CLKDIV_1KHZ   = SYS_CLK_HZ / 1_000;
  localparam int unsigned CLKDIV_100HZ  = SYS_CLK_HZ / 100;

  // Frequency meter: default gate window is one second of system clock.
  localparam int unsigned FM_GATE_CYCLES_DEF = SYS_CLK_HZ;

  typedef enum logic [1:0] {
    FM_IDLE  = 2'd0,
    FM_GATE  = 2'd1,
    FM_LATCH = 2'd2
  } fm_state_e;

endpackage

// File: rtl/sig_edge_sync.sv
// Brings an asynchronous pulse input into the clk_in domain and flags each
// rising edge as a single-cycle strobe, two cycles after sig_in is sampled.
module sig_edge_sync (
  input  logic clk_in,
  input  logic rst,
  input  logic sig_in,
  output logic rise
);

  logic s1, s2, s3;

  // Two-flop synchronizer (s1, s2) plus a history flop (s3) for edge detection.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour and the chain really shifts.
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of sig_in over a fixed window of GATE_CYCLES clk_in
// cycles and reports the count (saturating, with an overflow flag) once per
// completed window. Windows repeat back to back while enable is held high.
module freq_meter
  import minicar_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = FM_GATE_CYCLES_DEF,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_out,
  output logic             freq_valid,
  output logic             overflow
);

  localparam int unsigned GC_W = $clog2(GATE_CYCLES);
  localparam logic [GC_W-1:0]  GATE_LAST = GC_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  fm_state_e        state, state_next;
  logic [GC_W-1:0]  gate_cnt, gate_next;
  logic [CNT_W-1:0] edge_cnt, edge_next;
  logic             ovf_flag, ovf_next;
  logic             load;
  logic             rise;

  sig_edge_sync u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .sig_in (sig_in),
    .rise   (rise)
  );

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst) state <= FM_IDLE;
    else     state <= state_next;
  end

  // Next-state, window counters and the result-load decision.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_next = state;
    gate_next  = gate_cnt;
    edge_next  = edge_cnt;
    ovf_next   = ovf_flag;
    load       = 1'b0;
    unique case (state)
      FM_IDLE: begin
        if (enable) begin
          state_next = FM_GATE;
          gate_next  = '0;
          edge_next  = '0;
          ovf_next   = 1'b0;
        end
      end
      FM_GATE: begin
        if (!enable) begin
          // Window abandoned: results stay as they were.
          state_next = FM_IDLE;
        end else begin
          if (rise) begin
            if (edge_cnt == CNT_MAX) ovf_next  = 1'b1;
            else                     edge_next = edge_cnt + CNT_W'(1);
          end
          if (gate_cnt == GATE_LAST) begin
            // The edge seen on the final gate cycle is already in edge_next.
            state_next = FM_LATCH;
            load       = 1'b1;
          end else begin
            gate_next = gate_cnt + GC_W'(1);
          end
        end
      end
      FM_LATCH: begin
        // Edges in this cycle are dropped; the next window starts cleared.
        if (enable) begin
          state_next = FM_GATE;
          gate_next  = '0;
          edge_next  = '0;
          ovf_next   = 1'b0;
        end else begin
          state_next = FM_IDLE;
        end
      end
      default: state_next = FM_IDLE;
    endcase
  end

  // Window counters.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf_flag <= 1'b0;
    end else begin
      gate_cnt <= gate_next;
      edge_cnt <= edge_next;
      ovf_flag <= ovf_next;
    end
  end

  // Result registers, loaded on entry to LATCH so they are visible together
  // with freq_valid during the LATCH cycle.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      freq_out   <= '0;
      overflow   <= 1'b0;
      freq_valid <= 1'b0;
    end else begin
      freq_valid <= load;
      if (load) begin
        freq_out <= edge_next;
        overflow <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter. Two instances (CNT_W=4 and CNT_W=3)
// share the same stimulus; a window-level reference model recomputes each
// expected count from the recorded sig_in history.
module tb_freq_meter;
  import minicar_pkg::*;

  localparam int G = 20;

  logic       clk_in = 1'b0;
  logic       rst, enable, sig_in;
  logic [3:0] f4;
  logic       v4, o4;
  logic [2:0] f3;
  logic       v3, o3;

  always #5 clk_in = ~clk_in;

  freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) dut4 (
    .clk_in(clk_in), .rst(rst), .enable(enable), .sig_in(sig_in),
    .freq_out(f4), .freq_valid(v4), .overflow(o4)
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(3)) dut3 (
    .clk_in(clk_in), .rst(rst), .enable(enable), .sig_in(sig_in),
    .freq_out(f3), .freq_valid(v3), .overflow(o3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: sig_in value at each clock edge, window bookkeeping.
  bit hist [8192];
  int cyc    = 0;
  bit active = 1'b0;
  int g      = 0;
  bit exp_v  = 1'b0;
  int exp_f4 = 0, exp_o4 = 0, exp_f3 = 0, exp_o3 = 0;
  int valid_q[$];

  // Stimulus pattern selection for sig_in.
  int mode = 0, period = 4, rise_at = 0, npulse = 0;
  bit const_val = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // An edge is counted in cycle c when sig_in was sampled 0 then 1 at the
  // two edges before it (two-flop synchronizer delay).
  function automatic int count_edges(input int from, input int to);
    int n = 0;
    for (int c = from; c <= to; c++)
      if (hist[c-1] && !hist[c-2]) n++;
    return n;
  endfunction

  function automatic bit next_sig(input int n);
    case (mode)
      0:       return const_val;
      1:       return (n % period) >= (period / 2);
      2:       return 1'($urandom_range(0, 1));
      3:       return (n >= rise_at) && (n < rise_at + 3);
      default: return (n >= rise_at) && (n < rise_at + 4 * npulse) && (((n - rise_at) % 4) < 2);
    endcase
  endfunction

  // One clock: update the model at the edge, check outputs mid-cycle, then
  // drive sig_in for the next edge.
  task automatic step();
    int raw;
    @(posedge clk_in);
    cyc++;
    if (cyc < 8192) hist[cyc] = sig_in;
    exp_v = 1'b0;
    if (rst) begin
      if (cyc < 8192) hist[cyc] = 1'b0;
      active = 1'b0;
      exp_f4 = 0; exp_o4 = 0; exp_f3 = 0; exp_o3 = 0;
    end else if (!active) begin
      if (enable) begin
        active = 1'b1;
        g = cyc;
      end
    end else if (cyc <= g + G) begin
      if (!enable) begin
        active = 1'b0;
      end else if (cyc == g + G) begin
        raw    = count_edges(g, g + G - 1);
        exp_f4 = (raw > 15) ? 15 : raw;
        exp_o4 = (raw > 15) ? 1 : 0;
        exp_f3 = (raw > 7) ? 7 : raw;
        exp_o3 = (raw > 7) ? 1 : 0;
        exp_v  = 1'b1;
      end
    end else begin
      if (enable) g = cyc;
      else        active = 1'b0;
    end
    @(negedge clk_in);
    check("valid4", 32'(v4), 32'(exp_v));
    check("freq4",  32'(f4), 32'(exp_f4));
    check("ovf4",   32'(o4), 32'(exp_o4));
    check("valid3", 32'(v3), 32'(exp_v));
    check("freq3",  32'(f3), 32'(exp_f3));
    check("ovf3",   32'(o3), 32'(exp_o3));
    if (v4) valid_q.push_back(cyc);
    sig_in = next_sig(cyc + 1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Steps until the model expects a result; ends at the LATCH cycle.
  task automatic run_until_latch(input int max_cycles);
    int k = 0;
    do begin
      step();
      k++;
    end while (!exp_v && k < max_cycles);
    n_tests++;
    assert (exp_v) else begin
      n_fail++;
      $error("FAIL latch_timeout: no window completed within %0d cycles (cycle %0d)", max_cycles, cyc);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; sig_in = 1'b0;
    mode = 0; const_val = 1'b0;

    // Reset state.
    run(3);
    check("rst_freq", 32'(f4), 0);
    check("rst_valid", 32'(v4), 0);
    check("rst_ovf", 32'(o4), 0);
    rst = 1'b0;
    run(2);

    // Periodic input, period 4: five edges per window, strobe every 21 cycles.
    mode = 1; period = 4; enable = 1'b1;
    run_until_latch(40);
    valid_q.delete();
    for (int w = 0; w < 3; w++) begin
      run_until_latch(40);
      check("per4_freq", 32'(f4), 5);
      check("per4_ovf", 32'(o4), 0);
    end
    for (int i = 1; i < valid_q.size(); i++)
      check("per4_gap", 32'(valid_q[i] - valid_q[i-1]), 21);

    // Abort: enable dropped on gate cycle 10, previous result kept.
    step();
    while (cyc < g + 10) step();
    enable = 1'b0;
    valid_q.delete();
    run(30);
    check("abort_nvalid", 32'(valid_q.size()), 0);
    check("abort_freq", 32'(f4), 5);
    check("abort_ovf", 32'(o4), 0);
    check("abort_state", 32'(dut4.state), 32'(FM_IDLE));

    // Saturation: period 2 gives ten edges per window.
    mode = 1; period = 2; enable = 1'b1;
    run_until_latch(40);
    run_until_latch(40);
    check("sat_freq3", 32'(f3), 7);
    check("sat_ovf3", 32'(o3), 1);
    check("sat_freq4", 32'(f4), 10);
    check("sat_ovf4", 32'(o4), 0);
    // Following window with exactly three edges.
    enable = 1'b0; mode = 0; const_val = 1'b0;
    run(4);
    enable = 1'b1;
    step();
    mode = 4; rise_at = g + 2; npulse = 3;
    run_until_latch(40);
    check("three_freq3", 32'(f3), 3);
    check("three_ovf3", 32'(o3), 0);

    // Reset in the middle of a window.
    mode = 1; period = 2;
    step();
    while (cyc < g + 7) step();
    rst = 1'b1;
    step();
    check("midrst_freq", 32'(f4), 0);
    check("midrst_valid", 32'(v4), 0);
    check("midrst_ovf3", 32'(o3), 0);
    rst = 1'b0;
    run_until_latch(40);

    // Boundary edges: detected on the final gate cycle, then in LATCH.
    enable = 1'b0; mode = 0; const_val = 1'b0;
    run(4);
    enable = 1'b1;
    step();
    mode = 3; rise_at = g + 18;
    run_until_latch(40);
    check("last_cycle_edge", 32'(f4), 1);
    step();
    mode = 3; rise_at = g + 19;
    run_until_latch(40);
    check("latch_edge_win", 32'(f4), 0);
    run_until_latch(40);
    check("latch_edge_next", 32'(f4), 0);

    // Static high input: no edges.
    mode = 0; const_val = 1'b1;
    run_until_latch(40);
    for (int w = 0; w < 2; w++) begin
      run_until_latch(40);
      check("static_freq", 32'(f4), 0);
    end

    // Randomized input, continuous windows then random enable.
    mode = 2;
    for (int w = 0; w < 4; w++) run_until_latch(40);
    for (int i = 0; i < 200; i++) begin
      enable = ($urandom_range(0, 15) != 0);
      step();
    end
    enable = 1'b1;
    run_until_latch(60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 The block SHALL have one clock, clk_in, and one reset, rst; rst SHALL be synchronous and active-high.
REQ-002 Parameter GATE_CYCLES, default 100000000, SHALL set the measurement window length in clk_in cycles (1 s at 100 MHz); legal range is 2 or more.
REQ-003 Parameter CNT_W, default 16, SHALL set the width of the edge count.
REQ-004 clk_in  input  1  system clock, 100 MHz nominal.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 enable  input  1  run continuous measurement windows while high.
REQ-007 sig_in  input  1  asynchronous pulse input (e.g. wheel encoder or divided test clock).
REQ-008 freq_out  output  CNT_W  rising-edge count of the last completed window.
REQ-009 freq_valid  output  1  one-cycle strobe when freq_out updates.
REQ-010 overflow  output  1  last completed window saturated the count.

Function
REQ-011 sig_in SHALL pass through a 2-flop synchronizer (s1, s2), then a third flop s3.
REQ-012 A rising edge is detected on a cycle where s2=1 and s3=0.
- Latency from a sig_in transition, sampled at a clk_in edge, to edge detect: 2 cycles.
REQ-013 FSM states SHALL be IDLE, GATE and LATCH; the reset state is IDLE.
REQ-014 From IDLE, when enable=1 the FSM SHALL move to GATE, with the gate counter and edge counter at 0 on the first GATE cycle.
REQ-015 The GATE state SHALL last exactly GATE_CYCLES cycles.
- Gate counter runs 0..GATE_CYCLES-1.
- Every detected edge in GATE increments the edge counter, including the edge on the final cycle.
REQ-016 The edge counter SHALL saturate at 2^CNT_W-1; an edge arriving while saturated SHALL set an internal overflow flag for the window.
REQ-017 When the gate counter reaches GATE_CYCLES-1 with enable=1, the next state SHALL be LATCH.
REQ-018 LATCH SHALL last one cycle, in which:
- freq_out and overflow load the window's count and flag;
- freq_valid=1;
- edges detected in this cycle are discarded.
REQ-019 After LATCH, the FSM SHALL go to GATE (counters cleared) if enable=1, else to IDLE.
- With enable held high, freq_valid therefore strobes every GATE_CYCLES+1 cycles.
REQ-020 If enable=0 on any GATE cycle, including the final one, the FSM SHALL go to IDLE and abandon the window.
- No freq_valid is produced.
- freq_out and overflow keep their previous values.
REQ-021 freq_valid SHALL be 0 in all states except LATCH.
REQ-022 freq_out and overflow SHALL change only in LATCH or on reset.

Reset
REQ-023 When rst=1 at a clk_in edge, the following SHALL all clear to 0, overriding any in-progress window:
- state to IDLE;
- s1, s2, s3;
- gate counter and edge counter;
- freq_out, freq_valid, overflow.
REQ-024 After rst deasserts, the first window SHALL start only via the IDLE->GATE transition; no partial window is reported.

Structure
REQ-025 The FSM state encoding and the GATE_CYCLES default SHALL live in the shared miniCar package, alongside the clock-divider constants.
REQ-026 The gate counter width SHALL be derived from GATE_CYCLES using clog2.
REQ-027 The synchronizer and edge detector SHALL be one sub-module, sig_edge_sync, with ports clk_in, rst, sig_in and rise.
REQ-028 freq_meter SHALL use no derived clocks; all logic runs on clk_in.

Verification (bench: GATE_CYCLES=20, CNT_W=4 unless stated)
REQ-029 Periodic input: enable=1, sig_in period 4 cycles -> freq_out=5, overflow=0, freq_valid pulses every 21 cycles.
REQ-030 Saturation: CNT_W=3, sig_in period 2 cycles -> 10 edges in window -> freq_out=7, overflow=1; a following window of 3 edges -> freq_out=3, overflow=0.
REQ-031 Abort: previous freq_out=5; enable dropped on gate cycle 10 -> no freq_valid, freq_out stays 5, FSM in IDLE.
REQ-032 Reset mid-window: rst=1 on gate cycle 7 with 3 edges counted -> next cycle all outputs 0; re-enable -> first result reflects only post-reset edges.
REQ-033 Boundary edges:
- Single edge detected on gate cycle 19 -> freq_out=1.
- Single edge detected in the LATCH cycle -> next window does not count it.
REQ-034 Static input: sig_in held 1 throughout -> freq_out=0 every window.
